port_traffic_gen: RTL and testbench
===================================

Name: port_traffic_gen

Overview:
- Synthesizable pseudo-random packet source that drives one switch_4port input port (valid_in, source_in, target_in, data_in).
- Sits directly upstream of the switch port.
- Used for gate-level and SDF bring-up, where the class-based driver and the hierarchical FIFO peeks are unavailable.
- Reports packets sent and effective drops (counted per target) through hardware counters.

Parameters:
- PORT_ID, 0: index of the driven port; sets source field and the excluded target bit.
- NUM_PORTS, 4: switch port count; target mask width.
- DATA_WIDTH, 8: payload width.
- CNT_WIDTH, 16: width of sent_cnt and drop_cnt.
- BACKOFF, 1: 1 = hold packet while fifo_full_in; 0 = fire anyway and count drop.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when idle
- num_pkts  in  16  packets in run; sampled on start
- seed  in  16  LFSR seed; sampled on start; 0 replaced by 16'hACE1
- gap_max  in  4  mask applied to random inter-packet gap
- fifo_full_in  in  1  full flag of the driven port's input FIFO
- valid_out  out  1  packet strobe to switch valid_in
- source_out  out  4  equals PORT_ID
- target_out  out  NUM_PORTS  destination mask
- data_out  out  DATA_WIDTH  payload
- busy  out  1  run in progress
- done  out  1  run complete; held until next accepted start
- sent_cnt  out  CNT_WIDTH  valid_out cycles in current run, saturating
- drop_cnt  out  CNT_WIDTH  sum of popcount(target_out) over cycles with valid_out & fifo_full_in, saturating

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; LFSR = 16'hACE1.
  - All outputs 0, including counters and done.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances exactly once per cycle while busy; frozen otherwise.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE / DONE + start:
  - Load LFSR from seed; clear counters and done; latch num_pkts and gap_max.
  - num_pkts == 0 → DONE next cycle.
  - Otherwise → SEND next cycle.
- start while busy is ignored.
- SEND:
  - Fields derived combinationally from current LFSR:
    - type = lfsr[1:0]: 00/01 unicast, 10 multicast, 11 broadcast.
    - idx = lfsr[3:2]; if idx == PORT_ID, idx = (idx+1) mod NUM_PORTS.
    - others = all ones with bit PORT_ID cleared.
    - unicast target = 1<<idx; multicast = others & ~(1<<idx), two bits set; broadcast = others.
    - data = lfsr[15:8].
  - Target bit PORT_ID is never set; target is never 0.
  - BACKOFF=1 and fifo_full_in: valid_out = 0 and stay in SEND. Fields are regenerated each cycle; the stall is not counted as a drop.
  - Otherwise: valid_out = 1 for exactly this cycle; sent_cnt++.
    - BACKOFF=0 with fifo_full_in: drop_cnt += popcount(target).
    - Then take the post-packet transition.
- Post-packet transition:
  - Last packet → DONE.
  - Else g = lfsr[11:8] & gap_max; g == 0 → stay in SEND (back-to-back); else GAP with counter g.
- GAP: valid_out = 0; counter decrements; → SEND when the counter reaches 1, giving exactly g idle cycles.
- Output registering:
  - All outputs registered.
  - valid_out and its fields change together.
  - Fields are zeroed when valid_out = 0.
- Status: busy = SEND|GAP; done = DONE.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-run: immediate return to reset values; no partial packet is emitted.

Decomposition:
- packet_pkg additions:
  - pkt_type_e enum (UNICAST, MULTICAST, BROADCAST).
  - LFSR_TAPS and LFSR_DEFAULT_SEED constants.
  - gen_state_e enum.
  - Function other_ports_mask(port_id).
- One sub-module: lfsr16, with load, enable and seed inputs and a state output.

Test Plan:
- num_pkts=0, start → busy never high; done=1 one cycle after start; sent_cnt=0.
- num_pkts=5, gap_max=0, fifo_full_in=0 → valid_out high for 5 consecutive cycles starting one cycle after start; sent_cnt=5; drop_cnt=0; done next cycle.
- PORT_ID=2, num_pkts=1000, gap_max=4'hF:
  - target_out[2] is never 1 and target_out is never 0.
  - popcount is 1, 2 or 3 matching the type.
  - source_out is always 2.
  - Every gap is ≤15.
- BACKOFF=0, fifo_full_in held 1, num_pkts=8 → sent_cnt=8; drop_cnt equals the bench sum of popcount(target_out) over the 8 strobes.
- BACKOFF=1: fifo_full_in high for 10 cycles after start, then low; num_pkts=3, gap_max=0 → no valid_out during the 10 cycles; then 3 strobes; drop_cnt=0.
- rst_n pulsed low during GAP of a 100-packet run → all outputs 0 asynchronously; IDLE after release; new start with the same seed reproduces an identical packet sequence.

Source files
------------

// File: rtl/port_traffic_gen_pkg.sv
// Shared types, constants and helpers for the port traffic generator.
package port_traffic_gen_pkg;

  // Widest port mask the helpers below handle.
  localparam int MAX_PORTS = 16;

  // Feedback taps at stages 16,14,13,11 (bit positions 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    UNICAST   = 2'd0,
    MULTICAST = 2'd1,
    BROADCAST = 2'd2
  } pkt_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } gen_state_e;

  // Mask with every existing port set except the generator's own.
  function automatic logic [MAX_PORTS-1:0] other_ports_mask(input int port_id, input int num_ports);
    logic [MAX_PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if ((i < num_ports) && (i != port_id)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Two LFSR bits select the packet kind; 00 and 01 both mean unicast.
  function automatic pkt_type_e decode_type(input logic [1:0] code);
    case (code)
      2'b10:   return MULTICAST;
      2'b11:   return BROADCAST;
      default: return UNICAST;
    endcase
  endfunction

  // Number of set bits in a port mask.
  function automatic logic [7:0] popcount(input logic [MAX_PORTS-1:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      cnt = cnt + {7'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/port_traffic_gen_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance enable.
// A zero seed would lock the register up, so it is swapped for the default.
module lfsr16
  import port_traffic_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic fb_s;

  assign fb_s = ^(state & LFSR_TAPS);

  // Shift register: load has priority over advance; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
    end else if (enable) begin
      state <= {state[14:0], fb_s};
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/port_traffic_gen.sv
// Pseudo-random packet source for one switch input port. Packet fields come
// from an LFSR, inter-packet gaps are random and masked, and sent / dropped
// traffic is tallied in saturating counters. All outputs are registered, so
// every output reflects the generator state of the previous cycle.
module port_traffic_gen
  import port_traffic_gen_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int BACKOFF    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           num_pkts,
  input  logic [15:0]           seed,
  input  logic [3:0]            gap_max,
  input  logic                  fifo_full_in,
  output logic                  valid_out,
  output logic [3:0]            source_out,
  output logic [NUM_PORTS-1:0]  target_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam logic [MAX_PORTS-1:0] OTHERS_FULL = other_ports_mask(PORT_ID, NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] OTHERS      = OTHERS_FULL[NUM_PORTS-1:0];
  localparam logic [1:0]           PORT_IDX    = PORT_ID[1:0];
  localparam logic [3:0]           SOURCE_ID   = PORT_ID[3:0];
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  gen_state_e            state_r, state_nxt_s;
  logic [15:0]           rem_r, rem_nxt_s;
  logic [3:0]            gap_r, gap_nxt_s;
  logic [3:0]            gap_max_r;
  logic [15:0]           lfsr_s;
  logic                  lfsr_load_s, lfsr_en_s, lfsr_stuck_s;
  logic [15:0]           lfsr_seed_s;
  logic                  start_acc_s, emit_s;
  logic [1:0]            idx_s;
  logic [NUM_PORTS-1:0]  onehot_s, target_s;
  logic [MAX_PORTS-1:0]  target_ext_s;
  logic [7:0]            pop_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [3:0]            gap_s;
  logic [CNT_WIDTH:0]    drop_sum_s;

  // A zero LFSR can only come from an upset; recover by reloading the default.
  assign lfsr_stuck_s = (lfsr_s == 16'd0);
  assign lfsr_load_s  = start_acc_s | lfsr_stuck_s;
  assign lfsr_seed_s  = start_acc_s ? seed : LFSR_DEFAULT_SEED;
  assign lfsr_en_s    = (state_r == SEND) || (state_r == GAP);

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load_s),
    .enable (lfsr_en_s),
    .seed   (lfsr_seed_s),
    .state  (lfsr_s)
  );

  // Packet fields, gap length and drop tally derived from the current LFSR.
  always_comb begin
    idx_s = lfsr_s[3:2];
    if (idx_s == PORT_IDX) begin
      idx_s = (int'(idx_s) == NUM_PORTS - 1) ? 2'd0 : idx_s + 2'd1;
    end else begin
      idx_s = lfsr_s[3:2];
    end
    onehot_s = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx_s;
    case (decode_type(lfsr_s[1:0]))
      UNICAST:   target_s = onehot_s;
      MULTICAST: target_s = OTHERS & ~onehot_s;
      BROADCAST: target_s = OTHERS;
      default:   target_s = onehot_s;
    endcase
    target_ext_s                  = '0;
    target_ext_s[NUM_PORTS-1:0]   = target_s;
    pop_s      = popcount(target_ext_s);
    data_s     = DATA_WIDTH'(lfsr_s[15:8]);
    gap_s      = lfsr_s[11:8] & gap_max_r;
    drop_sum_s = {1'b0, drop_cnt} + {{(CNT_WIDTH-7){1'b0}}, pop_s};
  end

  // Next-state logic: run control, packet emission and gap countdown.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    gap_nxt_s   = gap_r;
    start_acc_s = 1'b0;
    emit_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          start_acc_s = 1'b1;
          rem_nxt_s   = num_pkts;
          state_nxt_s = (num_pkts == 16'd0) ? DONE : SEND;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SEND: begin
        if ((BACKOFF != 0) && fifo_full_in) begin
          state_nxt_s = SEND;
        end else begin
          emit_s = 1'b1;
          if (rem_r <= 16'd1) begin
            state_nxt_s = DONE;
          end else begin
            rem_nxt_s = rem_r - 16'd1;
            if (gap_s == 4'd0) begin
              state_nxt_s = SEND;
            end else begin
              state_nxt_s = GAP;
              gap_nxt_s   = gap_s;
            end
          end
        end
      end
      GAP: begin
        if (gap_r <= 4'd1) begin
          state_nxt_s = SEND;
        end else begin
          gap_nxt_s = gap_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control registers: FSM state, packets remaining, gap counter, gap mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rem_r     <= 16'd0;
      gap_r     <= 4'd0;
      gap_max_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      rem_r     <= rem_nxt_s;
      gap_r     <= gap_nxt_s;
      gap_max_r <= start_acc_s ? gap_max : gap_max_r;
    end
  end

  // Registered outputs: packet strobe with zeroed idle fields, status, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      source_out <= 4'd0;
      target_out <= '0;
      data_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      valid_out  <= emit_s;
      source_out <= emit_s ? SOURCE_ID : 4'd0;
      target_out <= emit_s ? target_s : '0;
      data_out   <= emit_s ? data_s : '0;
      busy       <= (state_r == SEND) || (state_r == GAP);
      done       <= (state_r == DONE) && !start_acc_s;
      if (start_acc_s) begin
        sent_cnt <= '0;
        drop_cnt <= '0;
      end else if (emit_s) begin
        sent_cnt <= (sent_cnt == CNT_MAX) ? CNT_MAX : sent_cnt + CNT_ONE;
        if (fifo_full_in) begin
          drop_cnt <= drop_sum_s[CNT_WIDTH] ? CNT_MAX : drop_sum_s[CNT_WIDTH-1:0];
        end else begin
          drop_cnt <= drop_cnt;
        end
      end else begin
        sent_cnt <= sent_cnt;
        drop_cnt <= drop_cnt;
      end
    end
  end

endmodule

// File: tb/tb_port_traffic_gen.sv
// Self-checking bench for port_traffic_gen. Instance A (PORT_ID=2, BACKOFF=1)
// is checked against a transaction-level scoreboard; instance B (PORT_ID=1,
// BACKOFF=0) covers drop counting with the FIFO held full.
module tb_port_traffic_gen;

  logic        clk;
  logic        rst_n;

  logic        a_start, a_full;
  logic [15:0] a_num, a_seed;
  logic [3:0]  a_gap;
  logic        a_valid, a_busy, a_done;
  logic [3:0]  a_src, a_tgt;
  logic [7:0]  a_data;
  logic [15:0] a_sent, a_drop;

  logic        b_start, b_full;
  logic [15:0] b_num, b_seed;
  logic [3:0]  b_gap;
  logic        b_valid, b_busy, b_done;
  logic [3:0]  b_src, b_tgt;
  logic [7:0]  b_data;
  logic [15:0] b_sent, b_drop;

  port_traffic_gen #(.PORT_ID(2), .NUM_PORTS(4), .DATA_WIDTH(8), .CNT_WIDTH(16), .BACKOFF(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .num_pkts(a_num), .seed(a_seed),
    .gap_max(a_gap), .fifo_full_in(a_full), .valid_out(a_valid), .source_out(a_src),
    .target_out(a_tgt), .data_out(a_data), .busy(a_busy), .done(a_done),
    .sent_cnt(a_sent), .drop_cnt(a_drop)
  );

  port_traffic_gen #(.PORT_ID(1), .NUM_PORTS(4), .DATA_WIDTH(8), .CNT_WIDTH(16), .BACKOFF(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .num_pkts(b_num), .seed(b_seed),
    .gap_max(b_gap), .fifo_full_in(b_full), .valid_out(b_valid), .source_out(b_src),
    .target_out(b_tgt), .data_out(b_data), .busy(b_busy), .done(b_done),
    .sent_cnt(b_sent), .drop_cnt(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tgt;
    logic [7:0] data;
    int         gap;
  } pkt_t;

  pkt_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int cyc;
  int a_strobes, a_idle, a_first, a_last, a_done_cyc, a_prev_gap;
  bit a_busy_seen, sb_en;
  int b_strobes, b_pop_sum;
  bit b_done_seen;
  bit aborted;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int pc4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  function automatic logic [3:0] exp_target(input logic [15:0] l, input int pid);
    logic [1:0] idx;
    logic [3:0] one, others;
    idx = l[3:2];
    if (int'(idx) == pid) idx = idx + 2'd1;
    one    = 4'b0001 << idx;
    others = 4'b1111 & ~(4'b0001 << pid);
    case (l[1:0])
      2'b10:   return others & ~one;
      2'b11:   return others;
      default: return one;
    endcase
  endfunction

  // Expected packet stream for a run without back-pressure.
  task automatic push_run(input logic [15:0] seed, input int num, input logic [3:0] gmax);
    logic [15:0] l;
    pkt_t p;
    l = (seed == 16'd0) ? 16'hACE1 : seed;
    for (int i = 0; i < num; i++) begin
      p.tgt  = exp_target(l, 2);
      p.data = l[15:8];
      p.gap  = int'(l[11:8] & gmax);
      exp_q.push_back(p);
      l = lfsr_step(l);
      for (int k = 0; k < p.gap; k++) l = lfsr_step(l);
    end
  endtask

  // One clock: sample both instances on the falling edge and score them.
  task automatic cycle();
    pkt_t p;
    @(negedge clk);
    cyc++;
    if (a_busy) a_busy_seen = 1'b1;
    if (a_done && a_done_cyc < 0) a_done_cyc = cyc;
    if (a_valid) begin
      a_strobes++;
      if (a_first < 0) a_first = cyc;
      a_last = cyc;
      chk_eq("a_source", a_src, 4'd2);
      chk_eq("a_tgt_self", a_tgt[2], 1'b0);
      chk_eq("a_tgt_nonzero", a_tgt != 4'd0, 1'b1);
      chk_eq("a_popcnt_range", (pc4(a_tgt) >= 1) && (pc4(a_tgt) <= 3), 1'b1);
      if (a_strobes > 1) chk_eq("a_gap_le15", a_idle <= 15, 1'b1);
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          chk_eq("a_sb_underflow", exp_q.size(), 1);
        end else begin
          p = exp_q.pop_front();
          if (a_strobes > 1) chk_eq("a_gap", a_idle, a_prev_gap);
          chk_eq("a_target", a_tgt, p.tgt);
          chk_eq("a_data", a_data, p.data);
          a_prev_gap = p.gap;
        end
      end
      a_idle = 0;
    end else begin
      a_idle++;
      chk_eq("a_idle_fields", {a_src, a_tgt, a_data}, 16'd0);
    end
    if (b_valid) begin
      b_strobes++;
      b_pop_sum += pc4(b_tgt);
      chk_eq("b_source", b_src, 4'd1);
      chk_eq("b_tgt_self", b_tgt[1], 1'b0);
      chk_eq("b_tgt_nonzero", b_tgt != 4'd0, 1'b1);
    end
    if (b_done) b_done_seen = 1'b1;
  endtask

  task automatic run_a(input logic [15:0] num, input logic [15:0] seed, input logic [3:0] gmax,
                       input int full_cycles, input bit use_sb, input int restart_at,
                       input bit abort_in_gap, input int budget);
    a_strobes = 0; a_idle = 0; a_first = -1; a_last = -1; a_done_cyc = -1;
    a_prev_gap = 0; a_busy_seen = 1'b0; sb_en = use_sb; aborted = 1'b0;
    if (use_sb) push_run(seed, int'(num), gmax);
    a_num = num; a_seed = seed; a_gap = gmax;
    a_full = (full_cycles > 0);
    a_start = 1'b1;
    cyc = 0;
    while (a_done_cyc < 0 && cyc < budget && !aborted) begin
      cycle();
      a_start = (cyc == restart_at);
      if (cyc == restart_at) a_num = 16'd1;
      if (cyc >= full_cycles) a_full = 1'b0;
      if (abort_in_gap && a_strobes >= 2 && !a_valid && a_idle == 1 && a_prev_gap >= 3) aborted = 1'b1;
    end
    a_start = 1'b0;
    a_full  = 1'b0;
    if (abort_in_gap) begin
      chk_eq("a_abort_in_gap", aborted, 1'b1);
    end else begin
      chk_eq("a_timeout", a_done_cyc >= 0, 1'b1);
      chk_eq("a_sent", a_sent, num);
      chk_eq("a_drop", a_drop, 16'd0);
      chk_eq("a_strobes", a_strobes, num);
      chk_eq("a_busy_seen", a_busy_seen, num != 16'd0);
      if (use_sb) chk_eq("a_sb_left", exp_q.size(), 0);
      if (num == 16'd0) begin
        chk_eq("a_done_latency", a_done_cyc, 2);
      end else begin
        chk_eq("a_done_latency", a_done_cyc, a_last + 1);
        chk_eq("a_first_strobe", a_first, (full_cycles > 0) ? full_cycles + 1 : 2);
        if (gmax == 4'd0) chk_eq("a_back_to_back", a_last - a_first + 1, num);
      end
    end
  endtask

  task automatic run_b(input logic [15:0] num, input logic [15:0] seed, input logic [3:0] gmax,
                       input int budget);
    b_strobes = 0; b_pop_sum = 0; b_done_seen = 1'b0;
    b_num = num; b_seed = seed; b_gap = gmax; b_full = 1'b1;
    b_start = 1'b1;
    cyc = 0;
    while (!b_done_seen && cyc < budget) begin
      cycle();
      b_start = 1'b0;
    end
    b_full = 1'b0;
    chk_eq("b_timeout", b_done_seen, 1'b1);
    chk_eq("b_strobes", b_strobes, num);
    chk_eq("b_sent", b_sent, num);
    chk_eq("b_drop", b_drop, b_pop_sum);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_full = 1'b0; a_num = 16'd0; a_seed = 16'd0; a_gap = 4'd0;
    b_start = 1'b0; b_full = 1'b0; b_num = 16'd0; b_seed = 16'd0; b_gap = 4'd0;
    cyc = 0; a_idle = 0; a_strobes = 0; a_done_cyc = 0; a_first = 0; a_last = 0;
    a_prev_gap = 0; sb_en = 1'b0; b_strobes = 0; b_pop_sum = 0;
    repeat (3) @(negedge clk);
    chk_eq("rst_a_outputs", {a_valid, a_src, a_tgt, a_data, a_busy, a_done, a_sent, a_drop}, 64'd0);
    chk_eq("rst_b_outputs", {b_valid, b_src, b_tgt, b_data, b_busy, b_done, b_sent, b_drop}, 64'd0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Empty run, then a short back-to-back run with an ignored mid-run start.
    run_a(16'd0, 16'h5A5A, 4'd0, 0, 1'b0, -1, 1'b0, 50);
    run_a(16'd5, 16'h1D2C, 4'd0, 0, 1'b1, 3, 1'b0, 100);
    // FIFO full for the first 10 cycles: stall, no drops.
    run_a(16'd3, 16'h7777, 4'd0, 10, 1'b0, -1, 1'b0, 100);
    // Long random run with zero seed (default seed substituted).
    run_a(16'd1000, 16'h0000, 4'hF, 0, 1'b1, -1, 1'b0, 20000);
    // Fire-anyway instance with the FIFO held full.
    run_b(16'd8, 16'h4321, 4'h3, 200);

    // Reset asserted inside a gap, then the same run repeated from scratch.
    run_a(16'd100, 16'hBEEF, 4'hF, 0, 1'b1, -1, 1'b1, 3000);
    rst_n = 1'b0;
    #1;
    chk_eq("midrun_rst_a", {a_valid, a_src, a_tgt, a_data, a_busy, a_done, a_sent, a_drop}, 64'd0);
    chk_eq("midrun_rst_b", {b_valid, b_src, b_tgt, b_data, b_busy, b_done, b_sent, b_drop}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_en = 1'b0;
    repeat (3) cycle();
    chk_eq("post_rst_idle", {a_busy, a_done, a_valid, a_sent}, 19'd0);
    run_a(16'd100, 16'hBEEF, 4'hF, 0, 1'b1, -1, 1'b0, 3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
